// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: iterative unsigned restoring divider.
// One quotient bit per clock; start/done handshake like the multiplier.
module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, ITER} state_t;

    state_t           state, state_n;
    logic [WIDTH:0]   a, a_n, a_sh, t;
    logic [WIDTH-1:0] q, q_n, m, m_n;
    logic [WIDTH-1:0] quot_n, rem_n;
    logic [CW-1:0]    count, count_n;
    logic             done_n, dbz_n;

    assign busy = (state == ITER);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            a           <= '0;
            q           <= '0;
            m           <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_n;
            a           <= a_n;
            q           <= q_n;
            m           <= m_n;
            count       <= count_n;
            quotient    <= quot_n;
            remainder   <= rem_n;
            done        <= done_n;
            div_by_zero <= dbz_n;
        end
    end

    always_comb begin
        state_n = state;
        a_n     = a;
        q_n     = q;
        m_n     = m;
        count_n = count;
        quot_n  = quotient;
        rem_n   = remainder;
        done_n  = 1'b0;
        dbz_n   = div_by_zero;
        // A never exceeds the divisor, so its MSB is zero before the shift
        a_sh    = (a << 1) | (WIDTH + 1)'(q[WIDTH-1]);
        t       = a_sh - {1'b0, m};
        case (state)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        a_n     = '0;
                        q_n     = dividend;
                        m_n     = divisor;
                        count_n = CW'(WIDTH);
                        state_n = ITER;
                    end else begin
                        quot_n = '1;
                        rem_n  = dividend;
                        dbz_n  = 1'b1;
                        done_n = 1'b1;
                    end
                end
            end
            ITER: begin
                if (t[WIDTH]) begin
                    a_n = a_sh;
                    q_n = {q[WIDTH-2:0], 1'b0};
                end else begin
                    a_n = t;
                    q_n = {q[WIDTH-2:0], 1'b1};
                end
                count_n = count - CW'(1);
                if (count == CW'(1)) begin
                    quot_n  = q_n;
                    rem_n   = a_n[WIDTH-1:0];
                    dbz_n   = 1'b0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed self-checking bench for seq_restoring_divider (WIDTH=8).
module tb_seq_restoring_divider;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_restoring_divider #(.WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start one op at the next negedge, then wait for done with a bound.
    task automatic run_op(input string tag, input logic [7:0] dd,
                          input logic [7:0] dv, input logic [7:0] eq,
                          input logic [7:0] er, input logic edbz,
                          input int elat);
        int lat;
        int bcnt;
        @(negedge clk);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
        lat  = 1;
        bcnt = 0;
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".lat"}, lat, elat);
        chk({tag, ".busycyc"}, bcnt, elat - 1);
        chk({tag, ".busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, ".q"}, 32'(quotient), 32'(eq));
        chk({tag, ".r"}, 32'(remainder), 32'(er));
        chk({tag, ".dbz"}, 32'(div_by_zero), 32'(edbz));
    endtask

    initial begin
        logic [7:0] hq_dd[3];
        logic [7:0] hq_dv[3];
        logic [7:0] hq_q[3];
        logic [7:0] hq_r[3];
        int         ndone;
        logic [7:0] rdd, rdv;

        // 1. reset values
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst.q", 32'(quotient), 32'd0);
        chk("rst.r", 32'(remainder), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.dbz", 32'(div_by_zero), 32'd0);
        run_op("d100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 9);

        // 2. edge operands
        run_op("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9);
        run_op("d5_9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 9);
        run_op("d0_3", 8'd0, 8'd3, 8'd0, 8'd0, 1'b0, 9);
        run_op("d255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 9);

        // 3. divide by zero, then a normal op clears the flag
        run_op("d42_0", 8'd42, 8'd0, 8'hFF, 8'd42, 1'b1, 1);
        run_op("d9_3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 9);

        // 4. start held high: back-to-back ops
        hq_dd = '{8'd200, 8'd17, 8'd255};
        hq_dv = '{8'd3, 8'd5, 8'd16};
        hq_q  = '{8'd66, 8'd3, 8'd15};
        hq_r  = '{8'd2, 8'd2, 8'd15};
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            dividend = hq_dd[i];
            divisor  = hq_dv[i];
            start    = 1'b1;
            for (int k = 1; k <= 9; k++) begin
                @(negedge clk);
                if (k < 9) begin
                    chk($sformatf("hold%0d.nodone%0d", i, k),
                        32'(done), 32'd0);
                    dividend = 8'($urandom);
                    divisor  = 8'($urandom_range(1, 255));
                end else begin
                    chk($sformatf("hold%0d.done", i), 32'(done), 32'd1);
                    chk($sformatf("hold%0d.q", i),
                        32'(quotient), 32'(hq_q[i]));
                    chk($sformatf("hold%0d.r", i),
                        32'(remainder), 32'(hq_r[i]));
                end
            end
        end
        start = 1'b0;
        @(negedge clk);
        chk("hold.end_busy", 32'(busy), 32'd0);

        // mid-op start pulse is ignored, not queued
        dividend = 8'd60;
        divisor  = 8'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        dividend = 8'd1;
        divisor  = 8'd1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pulse.done", 32'(done), 32'd1);
        chk("pulse.q", 32'(quotient), 32'd8);
        chk("pulse.r", 32'(remainder), 32'd4);
        @(negedge clk);
        chk("pulse.after_busy", 32'(busy), 32'd0);
        chk("pulse.after_done", 32'(done), 32'd0);

        // 5. reset mid-operation
        dividend = 8'd200;
        divisor  = 8'd13;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.done", 32'(done), 32'd0);
        chk("midrst.q", 32'(quotient), 32'd0);
        chk("midrst.r", 32'(remainder), 32'd0);
        chk("midrst.dbz", 32'(div_by_zero), 32'd0);
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("midrst.nodone", ndone, 0);
        run_op("d200_13", 8'd200, 8'd13, 8'd15, 8'd5, 1'b0, 9);

        // 6. random sweep with corner pairs
        run_op("d0_255", 8'd0, 8'd255, 8'd0, 8'd0, 1'b0, 9);
        run_op("d255_0", 8'd255, 8'd0, 8'hFF, 8'd255, 1'b1, 1);
        run_op("d0_0", 8'd0, 8'd0, 8'hFF, 8'd0, 1'b1, 1);
        for (int i = 0; i < 400; i++) begin
            rdd = 8'($urandom);
            rdv = (i % 16 == 0) ? 8'd0 : 8'($urandom);
            if (rdv == 8'd0)
                run_op("rnd", rdd, rdv, 8'hFF, rdd, 1'b1, 1);
            else
                run_op("rnd", rdd, rdv, rdd / rdv, rdd % rdv, 1'b0, 9);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
